// File: rtl/mux_stream_arb.sv
// ---------------------------------------------------------------------------
// mux_stream_arb
//   N-channel, WIDTH-bit registered stream multiplexer. One channel is granted
//   per cycle, either the channel named by sel (mode=0) or the next valid
//   channel in round-robin order after the last round-robin winner (mode=1).
//   The granted word is captured in a single output register that can be
//   drained and reloaded in the same cycle, so a full word per cycle flows
//   while out_ready stays high.
//
// Handshake: every stream uses valid/ready. A word moves on a rising edge
//   where valid and ready are both high. A producer holds its word until it
//   is taken, and ready never depends on the word's contents. At most one
//   in_ready bit is high in any cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   mode       0 = explicit select, 1 = round-robin
//   sel        channel index used in select mode
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   out_data   registered selected word
//   out_chan   channel index that out_data came from
//   out_valid  output register holds a word
//   out_ready  downstream takes the word
// ---------------------------------------------------------------------------
module mux_stream_arb #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Last round-robin winner; the scan starts one past it. Resetting to N-1
  // makes channel 0 the first candidate.
  logic [SELW-1:0] rr_ptr;

  logic            load_en;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic            xfer;

  // The register can take a new word when it is empty or being drained now.
  assign load_en = !out_valid || out_ready;

  // Grant selection. In select mode an out-of-range sel (possible when N is
  // not a power of two) simply yields no grant.
  always_comb begin
    int              t;
    logic [SELW-1:0] idx;
    grant_valid = 1'b0;
    grant       = '0;
    t           = 0;
    idx         = '0;
    if (!mode) begin
      if (int'(sel) < N) begin
        if (in_valid[sel]) begin
          grant_valid = 1'b1;
          grant       = sel;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        t = int'(rr_ptr) + k;
        if (t >= N) t = t - N;
        idx = SELW'(t);
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = idx;
        end
      end
    end
  end

  // Reset suppresses ready so nothing is accepted in a reset cycle.
  assign xfer = !rst && load_en && grant_valid;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (xfer) begin
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_chan  <= grant;
      out_valid <= 1'b1;
      // Select-mode traffic must not disturb the round-robin fairness order.
      if (mode) rr_ptr <= grant;
    end else if (out_ready) begin
      // Drained with nothing to replace it; data and channel hold.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_stream_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_stream_arb
//   Directed bench for mux_stream_arb (WIDTH=32, N=4). Expected output words
//   ({chan, data}) are queued as stimulus is driven and compared when the
//   DUT presents a word that the downstream side takes.
// ---------------------------------------------------------------------------
module tb_mux_stream_arb;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;
  localparam int EW    = SELW + WIDTH;

  logic               clk;
  logic               rst;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  mux_stream_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int c, input logic [WIDTH-1:0] v);
    in_data[c*WIDTH +: WIDTH] = v;
  endtask

  task automatic push_exp(input int c, input logic [WIDTH-1:0] v);
    logic [EW-1:0] e;
    e = {SELW'(c), v};
    exp_q.push_back(e);
  endtask

  // Move to the falling edge and act as the scoreboard: a word taken at the
  // coming rising edge is popped and compared here.
  task automatic to_neg();
    logic [EW-1:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL out_spurious: observed chan=%0d data=%h expected=no word", out_chan, out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_word", 64'({out_chan, out_data}), 64'(e));
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string tag);
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) set_data(c, 32'h5A5A_0000 + 32'(c));

    // 1. Reset with all channels valid.
    repeat (2) @(posedge clk);
    #1;
    to_neg();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_chan",  64'(out_chan),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    to_pos();
    rst = 1'b0;

    // 2. Select mode, sel=2, every channel valid.
    mode = 1'b0;
    sel  = 2'd2;
    for (int c = 0; c < N; c++) set_data(c, 32'h1111_0000 + 32'(c));
    set_data(2, 32'hDEADBEEF);
    in_valid = 4'b1111;
    push_exp(2, 32'hDEADBEEF);
    to_neg();
    check("sel2_in_ready", 64'(in_ready), 64'h4);
    to_pos();
    in_valid = 4'b0000;
    to_neg();
    check("idle_in_ready", 64'(in_ready), 64'd0);
    to_pos();
    drain_check("sel2_queue");

    // 3. Round-robin, all valid, 8 back-to-back words.
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < N; c++) set_data(c, 32'hC000_0000 + (32'(k) << 8) + 32'(c));
      push_exp(k % N, 32'hC000_0000 + (32'(k) << 8) + 32'(k % N));
      to_neg();
      check("rr4_in_ready", 64'(in_ready), 64'(4'b0001 << (k % N)));
      to_pos();
    end
    in_valid = 4'b0000;
    to_neg();
    to_pos();
    drain_check("rr4_queue");

    // 4. Round-robin with only channels 0 and 3 valid (pointer now at 3).
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (k % 2 == 0) ? 0 : 3;
      set_data(0, 32'hB000_0000 + 32'(k));
      set_data(3, 32'hB300_0000 + 32'(k));
      push_exp(c, (c == 0) ? 32'hB000_0000 + 32'(k) : 32'hB300_0000 + 32'(k));
      to_neg();
      check("rr03_in_ready", 64'(in_ready), (c == 0) ? 64'h1 : 64'h8);
      to_pos();
    end
    in_valid = 4'b0000;
    to_neg();
    to_pos();
    drain_check("rr03_queue");

    // 5. Backpressure: load ch1, stall 3 cycles while sel/mode/inputs move.
    mode      = 1'b0;
    sel       = 2'd1;
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_data(1, 32'h0000_1234);
    push_exp(1, 32'h0000_1234);
    to_neg();
    check("bp_load_in_ready", 64'(in_ready), 64'h2);
    to_pos();
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      mode = k[0];
      sel  = SELW'(k + 2);
      set_data(1, 32'hFFFF_0000 + 32'(k));
      to_neg();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data",  64'(out_data),  64'h1234);
      check("bp_out_chan",  64'(out_chan),  64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      to_pos();
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    to_neg();
    to_pos();
    drain_check("bp_queue");

    // 5b. Select-mode traffic left the pointer at 3: round-robin restarts at ch0.
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int c = 0; c < N; c++) set_data(c, 32'h7700_0000 + 32'(c));
    push_exp(0, 32'h7700_0000);
    to_neg();
    check("rr_after_sel_in_ready", 64'(in_ready), 64'h1);
    to_pos();
    in_valid = 4'b0000;
    to_neg();
    to_pos();
    drain_check("rr_after_sel_queue");

    // 6. Reset while a word is held and inputs are valid.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    to_neg();
    check("pre_rst_in_ready", 64'(in_ready), 64'h2);
    to_pos();
    rst = 1'b1;
    to_neg();
    check("mid_rst_out_valid", 64'(out_valid), 64'd1);
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    to_pos();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) set_data(c, 32'h9900_0000 + 32'(c));
    push_exp(0, 32'h9900_0000);
    to_neg();
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready",  64'(in_ready),  64'h1);
    to_pos();
    in_valid = 4'b0000;
    to_neg();
    to_pos();
    drain_check("post_rst_queue");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
